// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: one-hot grant, registered owner index and lock flag,
// grant frozen across fixed-length bursts and locked sequences, parked on DEFAULT_MASTER.
module ahb_arbiter #(
    parameter int MASTER_COUNT   = 3,
    parameter int DEFAULT_MASTER = 0,
    localparam int MSEL_BITS     = $clog2(MASTER_COUNT)
) (
    input  logic                    i_hclk,
    input  logic                    i_hreset,
    input  logic [MASTER_COUNT-1:0] i_hbusreq,
    input  logic [MASTER_COUNT-1:0] i_hlock,
    input  logic [1:0]              i_htrans,
    input  logic [2:0]              i_hburst,
    input  logic                    i_hready,
    output logic [MASTER_COUNT-1:0] o_hgrant,
    output logic [MSEL_BITS-1:0]    o_hmaster,
    output logic                    o_hmastlock
);

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [1:0]           TRANS_IDLE   = 2'd0;
    localparam logic [1:0]           TRANS_BUSY   = 2'd1;
    localparam logic [1:0]           TRANS_NONSEQ = 2'd2;
    localparam logic [1:0]           TRANS_SEQ    = 2'd3;
    localparam logic [MSEL_BITS-1:0] DEF_IDX      = MSEL_BITS'(DEFAULT_MASTER);
    localparam logic [MSEL_BITS:0]   MC_W         = (MSEL_BITS+1)'(MASTER_COUNT);

    state_t                  state_r, state_nxt_s;
    logic [3:0]              count_r, count_nxt_s;
    logic [MSEL_BITS-1:0]    gidx_r, gidx_nxt_s;
    logic [MSEL_BITS-1:0]    ptr_r, ptr_nxt_s;
    logic [MASTER_COUNT-1:0] grant_r;
    logic [MSEL_BITS-1:0]    hmaster_r;
    logic                    hmastlock_r;
    logic                    do_arb_s;
    logic                    rr_found_s;
    logic [MSEL_BITS-1:0]    rr_win_s;
    logic [MSEL_BITS:0]      cand_s;

    function automatic logic [MASTER_COUNT-1:0] onehot(input logic [MSEL_BITS-1:0] idx);
        logic [MASTER_COUNT-1:0] v;
        v      = {MASTER_COUNT{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Counter preload is the burst length minus two: the NONSEQ beat and the final SEQ beat.
    function automatic logic [3:0] burst_load(input logic [2:0] burst);
        case (burst)
            3'd2, 3'd3: burst_load = 4'd2;
            3'd4, 3'd5: burst_load = 4'd6;
            3'd6, 3'd7: burst_load = 4'd14;
            default:    burst_load = 4'd0;
        endcase
    endfunction

    // Round-robin scan starting just after the last winner; the last winner is reached last.
    always_comb begin
        rr_found_s = 1'b0;
        rr_win_s   = DEF_IDX;
        cand_s     = {(MSEL_BITS+1){1'b0}};
        for (int k = 1; k <= MASTER_COUNT; k++) begin
            cand_s = {1'b0, ptr_r} + (MSEL_BITS+1)'(k);
            if (cand_s >= MC_W) begin
                cand_s = cand_s - MC_W;
            end else begin
                cand_s = cand_s;
            end
            if (!rr_found_s && i_hbusreq[cand_s[MSEL_BITS-1:0]]) begin
                rr_found_s = 1'b1;
                rr_win_s   = cand_s[MSEL_BITS-1:0];
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Next-state: burst tracking and the grant decision.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        gidx_nxt_s  = gidx_r;
        ptr_nxt_s   = ptr_r;
        do_arb_s    = 1'b0;

        case (state_r)
            ARB: do_arb_s = 1'b1;
            BURST: begin
                case (i_htrans)
                    TRANS_SEQ: begin
                        if (count_r == 4'd0) begin
                            do_arb_s = 1'b1;
                        end else begin
                            count_nxt_s = count_r - 4'd1;
                        end
                    end
                    TRANS_BUSY: count_nxt_s = count_r;
                    default:    do_arb_s = 1'b1;
                endcase
            end
            default: do_arb_s = 1'b1;
        endcase

        if (do_arb_s) begin
            state_nxt_s = ARB;
            if (i_htrans == TRANS_NONSEQ && i_hburst >= 3'd2) begin
                state_nxt_s = BURST;
                count_nxt_s = burst_load(i_hburst);
            end else if (i_hlock[gidx_r] && i_hbusreq[gidx_r]) begin
                gidx_nxt_s = gidx_r;
            end else if (rr_found_s) begin
                gidx_nxt_s = rr_win_s;
                ptr_nxt_s  = rr_win_s;
            end else begin
                gidx_nxt_s = DEF_IDX;
            end
        end else begin
            gidx_nxt_s = gidx_r;
        end
    end

    // State and output registers; nothing moves while the slave stretches the cycle.
    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            state_r     <= ARB;
            count_r     <= 4'd0;
            gidx_r      <= DEF_IDX;
            ptr_r       <= DEF_IDX;
            grant_r     <= onehot(DEF_IDX);
            hmaster_r   <= DEF_IDX;
            hmastlock_r <= 1'b0;
        end else if (i_hready) begin
            state_r     <= state_nxt_s;
            count_r     <= count_nxt_s;
            gidx_r      <= gidx_nxt_s;
            ptr_r       <= ptr_nxt_s;
            grant_r     <= onehot(gidx_nxt_s);
            hmaster_r   <= gidx_r;
            hmastlock_r <= i_hlock[gidx_r];
        end else begin
            state_r     <= state_r;
            count_r     <= count_r;
        end
    end

    assign o_hgrant    = grant_r;
    assign o_hmaster   = hmaster_r;
    assign o_hmastlock = hmastlock_r;

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Round-robin bus arbiter that shares one AHB address/data path between MASTER_COUNT masters ahead of the slave decoder/read-mux.
- Drives the one-hot grant vector and the registered owner index (o_hmaster) that steers the master-side address/write-data mux.
- Keeps ownership for the whole of a fixed-length burst and for locked sequences.
- Parks the bus on DEFAULT_MASTER when no master requests.

Parameters:
- MASTER_COUNT, 3, number of bus masters (2..8).
- DEFAULT_MASTER, 0, master granted when no request is pending; also the reset owner.
- MSEL_BITS, $clog2(MASTER_COUNT), localparam, width of the master index.

Ports:
- i_hclk  input  1  bus clock; all timing on the rising edge.
- i_hreset  input  1  asynchronous, active-low reset.
- i_hbusreq  input  MASTER_COUNT  per-master bus request.
- i_hlock  input  MASTER_COUNT  per-master locked-access request.
- i_htrans  input  2  HTRANS of the current owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- i_hburst  input  3  HBURST of the current owner (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
- i_hready  input  1  muxed HREADY from the slave-side interconnect.
- o_hgrant  output  MASTER_COUNT  one-hot grant, registered.
- o_hmaster  output  MSEL_BITS  index of the master owning the address phase, registered.
- o_hmastlock  output  1  current address phase is locked, registered.

Behaviour:
- Reset (asynchronous, i_hreset=0):
  - o_hgrant = one-hot(DEFAULT_MASTER); o_hmaster = DEFAULT_MASTER; o_hmastlock = 0.
  - State = ARB; beat counter = 0; last-winner pointer = DEFAULT_MASTER.
  - Reset mid-burst aborts all state immediately.
- Clock gating: no register changes on an edge with i_hready=0. All updates below are qualified by i_hready=1.
- Ownership handoff: o_hmaster <= index(o_hgrant), and o_hmastlock <= i_hlock[index(o_hgrant)]. A newly granted master therefore owns the address phase one accepted cycle after its grant.
- State ARB (arbitration allowed):
  - If i_hlock[index(o_hgrant)]=1 and i_hbusreq of that master=1, hold the grant.
  - Otherwise select the first requesting master, scanning from (pointer+1) mod MASTER_COUNT upward with wrap. The current holder is also a candidate and is reached last.
  - No request: grant DEFAULT_MASTER; pointer unchanged.
  - On a new win: o_hgrant <= one-hot(winner); pointer <= winner.
  - If i_htrans=NONSEQ and i_hburst is WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16: load counter = length-2 (2/2/6/6/14/14), hold the grant, go to BURST.
  - SINGLE, INCR (undefined length), IDLE and BUSY stay in ARB.
- State BURST (grant frozen):
  - SEQ: if counter = 0, the last beat's address is accepted; return to ARB. The arbitration decision is made on this same edge. Otherwise decrement the counter.
  - BUSY: counter unchanged.
  - IDLE or NONSEQ (burst cancelled, e.g. after ERROR): return to ARB and arbitrate on this edge. A NONSEQ fixed-length burst reloads the counter as in ARB.
- Lock: the grant is never removed from a master while its i_hlock=1. Arbitration resumes on the first accepted edge with i_hlock low.
- Invariants:
  - o_hgrant is always exactly one-hot.
  - o_hmaster is always < MASTER_COUNT.
  - i_hbusreq/i_hlock bits of a master not holding the grant do not affect BURST.

Test Plan:
- Reset then idle bus, i_hbusreq=000 for 5 cycles, i_hready=1 -> o_hgrant=001, o_hmaster=0, o_hmastlock=0 throughout.
- Round-robin: i_hbusreq=111 held, SINGLE NONSEQ every cycle, i_hready=1 -> grant sequence 010,100,001,010; o_hmaster follows one cycle later (1,2,0,1).
- Burst hold: master 1 granted, issues INCR4 NONSEQ+3 SEQ while master 2 requests; insert one BUSY and two i_hready=0 wait states -> o_hgrant stays 010 until the 4th beat address is accepted, then 100 on that edge.
- Lock: master 2 asserts i_hlock with i_hbusreq for 6 transfers while masters 0/1 request -> o_hgrant=100 and o_hmastlock=1 for all 6 owned cycles; grant moves to master 0 on the first accepted edge with i_hlock[2]=0.
- Cancelled burst: master 0 issues INCR8 with an ERROR after beat 3, then IDLE; master 1 requesting -> grant moves to 010 on the IDLE-accepted edge.
- Reset mid-burst: i_hreset pulsed low during beat 5 of INCR16 by master 2 -> outputs return to 001/0/0 asynchronously; the next burst from master 2 is counted from scratch.
